// File: rtl/n64_pi_pkg.sv
// Shared types and constants for the N64 parallel-interface (PI) read master.
package n64_pi_pkg;

  // Width of the multiplexed cartridge address/data bus.
  localparam int PI_AD_W = 16;

  // Phase timer width; every timing parameter fits in 1..255 cycles.
  localparam int PI_TMR_W = 8;

  // Default phase timings in clock cycles.
  localparam int DEF_ALE_CYC     = 4;
  localparam int DEF_RD_LOW_CYC  = 8;
  localparam int DEF_RD_HIGH_CYC = 4;

  // Bus-cycle phases: idle, address high, address low, turnaround, read low, read high.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AHI  = 3'd1,
    ST_ALO  = 3'd2,
    ST_GAP  = 3'd3,
    ST_RDL  = 3'd4,
    ST_RDH  = 3'd5
  } pi_state_e;

  // The timer counts down to zero, so a phase of N cycles is loaded with N-1.
  function automatic logic [PI_TMR_W-1:0] cyc_to_load(input int cyc);
    return PI_TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/n64_pi_timer.sv
// Loadable down-counter that times every PI bus phase; done is high at zero.
module n64_pi_timer
  import n64_pi_pkg::*;
#(
  parameter int W = PI_TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Reload on phase entry, otherwise count down and park at zero.
  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/n64_pi_master.sv
// N64 cartridge PI bus read master: issues an address phase (ALE_H/ALE_L),
// then reads halfword bursts with READ_N strobes, re-issuing the address
// whenever the low 16 bits of the address wrap.
// Optional build macro N64_PI_MASTER_INPUT_REG_EN: registers pi_ad_i before
// sampling, which delays resp_valid by one cycle (RDH length is unchanged).
module n64_pi_master
  import n64_pi_pkg::*;
#(
  parameter int ALE_CYC     = DEF_ALE_CYC,
  parameter int RD_LOW_CYC  = DEF_RD_LOW_CYC,
  parameter int RD_HIGH_CYC = DEF_RD_HIGH_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic [7:0]         req_len,
  output logic               resp_valid,
  output logic [PI_AD_W-1:0] resp_data,
  output logic               resp_last,
  output logic               busy,
  output logic [PI_AD_W-1:0] pi_ad_o,
  output logic               pi_ad_oe,
  input  logic [PI_AD_W-1:0] pi_ad_i,
  output logic               pi_ale_h,
  output logic               pi_ale_l,
  output logic               pi_read_n
);

  localparam logic [PI_TMR_W-1:0] ALE_LD = cyc_to_load(ALE_CYC);
  localparam logic [PI_TMR_W-1:0] RDL_LD = cyc_to_load(RD_LOW_CYC);
  localparam logic [PI_TMR_W-1:0] RDH_LD = cyc_to_load(RD_HIGH_CYC);

  pi_state_e             state;
  pi_state_e             state_next;
  logic                  tmr_load;
  logic [PI_TMR_W-1:0]   tmr_val;
  logic                  tmr_done;
  logic [31:0]           addr;
  logic [31:0]           addr_inc;
  logic [7:0]            remaining;
  logic                  armed;
  logic                  accept;
  logic                  rdl_end;
  logic                  sample_fire;
  logic [PI_AD_W-1:0]    sample_data;

  assign addr_inc  = addr + 32'd2;
  assign req_ready = armed && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign rdl_end   = (state == ST_RDL) && tmr_done;

  n64_pi_timer #(
    .W(PI_TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Hold req_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Phase state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-phase selection, timer reload on phase entry, and bus strobes.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    pi_ale_h   = 1'b0;
    pi_ale_l   = 1'b0;
    pi_read_n  = 1'b1;
    pi_ad_oe   = 1'b0;
    pi_ad_o    = '0;

    unique case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_AHI;
      end
      ST_AHI: begin
        pi_ale_h = 1'b1;
        pi_ale_l = 1'b1;
        pi_ad_oe = 1'b1;
        pi_ad_o  = addr[31:16];
        if (tmr_done) state_next = ST_ALO;
      end
      ST_ALO: begin
        pi_ale_l = 1'b1;
        pi_ad_oe = 1'b1;
        pi_ad_o  = addr[15:0];
        if (tmr_done) state_next = ST_GAP;
      end
      ST_GAP: begin
        // Neither side drives the bus while it turns around.
        if (tmr_done) state_next = ST_RDL;
      end
      ST_RDL: begin
        pi_read_n = 1'b0;
        if (tmr_done) state_next = ST_RDH;
      end
      ST_RDH: begin
        if (tmr_done) begin
          if (remaining == 8'd0) begin
            state_next = ST_IDLE;
          end else if (addr_inc[15:0] == 16'h0000) begin
            // The cartridge only auto-increments the low half, so a carry
            // into the upper half needs a fresh address phase.
            state_next = ST_AHI;
          end else begin
            state_next = ST_RDL;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (state_next != state) begin
      tmr_load = 1'b1;
      unique case (state_next)
        ST_AHI, ST_ALO, ST_GAP: tmr_val = ALE_LD;
        ST_RDL:                 tmr_val = RDL_LD;
        ST_RDH:                 tmr_val = RDH_LD;
        default:                tmr_val = '0;
      endcase
    end
  end

  // Burst address and remaining count: latched on accept, stepped at the end of RDH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (accept) begin
      addr      <= req_addr & ~32'd1;
      remaining <= req_len;
    end else if ((state == ST_RDH) && tmr_done) begin
      addr <= addr_inc;
      if (remaining != 8'd0) remaining <= remaining - 8'd1;
    end
  end

`ifdef N64_PI_MASTER_INPUT_REG_EN
  logic [PI_AD_W-1:0] ad_q;
  logic               sample_pend;

  // Register the pad input; the sample taken on the last RDL cycle is used one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_q        <= '0;
      sample_pend <= 1'b0;
    end else begin
      ad_q        <= pi_ad_i;
      sample_pend <= rdl_end;
    end
  end

  assign sample_fire = sample_pend;
  assign sample_data = ad_q;
`else
  assign sample_fire = rdl_end;
  assign sample_data = pi_ad_i;
`endif

  // Response pulse; remaining is still the pre-decrement count when sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_last  <= 1'b0;
    end else begin
      resp_valid <= sample_fire;
      resp_last  <= sample_fire && (remaining == 8'd0);
      if (sample_fire) resp_data <= sample_data;
    end
  end

endmodule

// File: tb/tb_n64_pi_master.sv
// Self-checking bench for n64_pi_master: a cartridge model answers reads,
// a monitor records bus phases and responses, and each burst is compared
// against the expected halfword sequence derived from the request alone.
module tb_n64_pi_master;
  import n64_pi_pkg::*;

  localparam int ALE = 4;
  localparam int RDL = 8;
  localparam int RDH = 4;
`ifdef N64_PI_MASTER_INPUT_REG_EN
  localparam int RESP_LAT = 1;
`else
  localparam int RESP_LAT = 0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [31:0]        req_addr = '0;
  logic [7:0]         req_len = '0;
  logic               resp_valid;
  logic [PI_AD_W-1:0] resp_data;
  logic               resp_last;
  logic               busy;
  logic [PI_AD_W-1:0] pi_ad_o;
  logic               pi_ad_oe;
  logic [PI_AD_W-1:0] pi_ad_i;
  logic               pi_ale_h;
  logic               pi_ale_l;
  logic               pi_read_n;

  int checks = 0;
  int failures = 0;

  n64_pi_master #(
    .ALE_CYC     (ALE),
    .RD_LOW_CYC  (RDL),
    .RD_HIGH_CYC (RDH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .busy       (busy),
    .pi_ad_o    (pi_ad_o),
    .pi_ad_oe   (pi_ad_oe),
    .pi_ad_i    (pi_ad_i),
    .pi_ale_h   (pi_ale_h),
    .pi_ale_l   (pi_ale_l),
    .pi_read_n  (pi_read_n)
  );

  always #5 clk = ~clk;

  // Cartridge content as a function of the full byte address.
  function automatic logic [15:0] cart_word(input int mode, input logic [31:0] a);
    if (mode == 0) return 16'h8037;
    if (mode == 1) return a[15:0];
    return a[31:16] ^ {a[7:0], a[15:8]} ^ 16'h5a5a;
  endfunction

  logic [15:0] cart_hi = '0;
  logic [15:0] cart_lo = '0;
  int          cart_mode = 0;

  always_comb pi_ad_i = cart_word(cart_mode, {cart_hi, cart_lo});

  // Monitor state.
  logic [15:0] resp_d_q[$];
  logic        resp_l_q[$];
  int          lat_q[$];
  int          resp_cyc_q[$];
  int          acc_cyc_q[$];
  logic [15:0] hi_q[$];
  logic [15:0] lo_q[$];
  int ale_h_cyc = 0, ale_l_cyc = 0, overlap_cnt = 0, accept_cnt = 0;
  int rdl_falls = 0, ready_busy_cnt = 0, cyc = 0, rdh_cyc = 0;
  logic prev_rn = 1'b1;
  logic prev_ale_h = 1'b0;

  // Cartridge latch/increment behaviour and bus observation, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (pi_ale_h && pi_ale_l) cart_hi = pi_ad_o;
    if (!pi_ale_h && pi_ale_l) cart_lo = pi_ad_o;
    if (pi_read_n && !prev_rn) begin
      cart_lo = cart_lo + 16'd2;
      rdh_cyc = cyc;
    end
    if (!pi_read_n && prev_rn) rdl_falls++;
    if (pi_ale_h && !prev_ale_h) hi_q.push_back(pi_ad_o);
    if (pi_ale_l && !pi_ale_h && prev_ale_h) lo_q.push_back(pi_ad_o);
    if (pi_ale_h) ale_h_cyc++;
    if (pi_ale_l) ale_l_cyc++;
    if (pi_ad_oe && !pi_read_n) overlap_cnt++;
    if (req_ready && busy) ready_busy_cnt++;
    if (resp_valid) begin
      resp_d_q.push_back(resp_data);
      resp_l_q.push_back(resp_last);
      lat_q.push_back(cyc - rdh_cyc);
      resp_cyc_q.push_back(cyc);
    end
    prev_rn = pi_read_n;
    prev_ale_h = pi_ale_h;
  end

  // Handshakes complete on the rising edge.
  always @(posedge clk) begin
    if (req_valid && req_ready) begin
      accept_cnt++;
      acc_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    resp_d_q.delete(); resp_l_q.delete(); lat_q.delete(); resp_cyc_q.delete();
    acc_cyc_q.delete(); hi_q.delete(); lo_q.delete();
    ale_h_cyc = 0; ale_l_cyc = 0; overlap_cnt = 0; accept_cnt = 0;
    rdl_falls = 0; ready_busy_cnt = 0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [7:0] l);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("issue/ready_wait", {31'd0, req_ready}, 32'd1);
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle/timeout", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Expected behaviour from the request alone: one halfword per 2-byte step,
  // a new address phase at the start and at every 64 KiB boundary.
  task automatic verify(input string tag, input logic [31:0] a, input int l,
                        input int mode, input int reps);
    logic [31:0] base, ad;
    logic [15:0] ed[$];
    logic        el[$];
    logic [15:0] eh[$];
    logic [15:0] elo[$];
    int          nr, np;
    base = a & ~32'd1;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i <= l; i++) begin
        ad = base + 32'(2 * i);
        ed.push_back(cart_word(mode, ad));
        el.push_back(i == l);
        if (i == 0 || ad[15:0] == 16'h0000) begin
          eh.push_back(ad[31:16]);
          elo.push_back(ad[15:0]);
        end
      end
    end
    check({tag, "/resp_count"}, resp_d_q.size(), ed.size());
    nr = (resp_d_q.size() < ed.size()) ? resp_d_q.size() : ed.size();
    for (int i = 0; i < nr; i++) begin
      check({tag, "/data"}, {16'd0, resp_d_q[i]}, {16'd0, ed[i]});
      check({tag, "/last"}, {31'd0, resp_l_q[i]}, {31'd0, el[i]});
      check({tag, "/latency"}, lat_q[i], RESP_LAT);
    end
    check({tag, "/addr_phases_hi"}, hi_q.size(), eh.size());
    check({tag, "/addr_phases_lo"}, lo_q.size(), elo.size());
    np = (hi_q.size() < eh.size()) ? hi_q.size() : eh.size();
    for (int i = 0; i < np; i++) check({tag, "/ad_hi"}, {16'd0, hi_q[i]}, {16'd0, eh[i]});
    np = (lo_q.size() < elo.size()) ? lo_q.size() : elo.size();
    for (int i = 0; i < np; i++) check({tag, "/ad_lo"}, {16'd0, lo_q[i]}, {16'd0, elo[i]});
    check({tag, "/ale_h_cycles"}, ale_h_cyc, eh.size() * ALE);
    check({tag, "/ale_l_cycles"}, ale_l_cyc, eh.size() * 2 * ALE);
    check({tag, "/oe_read_overlap"}, overlap_cnt, 0);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [7:0] l, input int mode);
    clear_mon();
    cart_mode = mode;
    issue(a, l);
    wait_idle();
    verify(tag, a, int'(l), mode, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    int          n;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst/req_ready", {31'd0, req_ready}, 32'd0);
    check("rst/busy", {31'd0, busy}, 32'd0);
    check("rst/resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst/resp_data", {16'd0, resp_data}, 32'd0);
    check("rst/resp_last", {31'd0, resp_last}, 32'd0);
    check("rst/read_n", {31'd0, pi_read_n}, 32'd1);
    check("rst/oe", {31'd0, pi_ad_oe}, 32'd0);
    check("rst/ale", {30'd0, pi_ale_h, pi_ale_l}, 32'd0);
    rst = 1'b0;
    #1 check("rst/ready_before_clock", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 check("rst/ready_after_clock", {31'd0, req_ready}, 32'd1);

    // Single read of the cartridge header word.
    run("single", 32'h1000_0000, 8'd0, 0);

    // Short burst, data equals the low address half.
    run("burst", 32'h1000_0040, 8'd3, 1);

    // 64 KiB boundary inside a burst forces a second address phase.
    run("wrap16", 32'h1000_FFFC, 8'd3, 2);

    // Full 32-bit address wrap, with bit 0 set (ignored).
    run("wrap32", 32'hFFFF_FFF9, 8'd5, 2);

    // Reset during the second RDL of a len=7 burst.
    clear_mon();
    cart_mode = 1;
    issue(32'h1000_2000, 8'd7);
    n = 0;
    while (rdl_falls < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("abort/reach_rdl2", rdl_falls, 2);
    #2 rst = 1'b1;
    #1;
    check("abort/read_n", {31'd0, pi_read_n}, 32'd1);
    check("abort/oe", {31'd0, pi_ad_oe}, 32'd0);
    check("abort/ale", {30'd0, pi_ale_h, pi_ale_l}, 32'd0);
    check("abort/busy", {31'd0, busy}, 32'd0);
    check("abort/req_ready", {31'd0, req_ready}, 32'd0);
    check("abort/resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort/resp_data", {16'd0, resp_data}, 32'd0);
    check("abort/resp_before", resp_d_q.size(), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("abort/ready_before_clock", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 check("abort/ready_after_clock", {31'd0, req_ready}, 32'd1);
    repeat (30) @(negedge clk);
    check("abort/no_more_resp", resp_d_q.size(), 1);
    check("abort/no_more_reads", rdl_falls, 2);

    // req_valid held high: second burst accepted only once idle.
    clear_mon();
    cart_mode = 1;
    @(negedge clk);
    req_addr  = 32'h1000_0100;
    req_len   = 8'd2;
    req_valid = 1'b1;
    n = 0;
    while (accept_cnt < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    check("hold/accepts", accept_cnt, 2);
    wait_idle();
    verify("hold", 32'h1000_0100, 2, 1, 2);
    check("hold/ready_while_busy", ready_busy_cnt, 0);
    if (acc_cyc_q.size() == 2 && resp_cyc_q.size() >= 3)
      check("hold/second_after_first", {31'd0, acc_cyc_q[1] > resp_cyc_q[2]}, 32'd1);
    else
      check("hold/event_counts", acc_cyc_q.size() * 100 + resp_cyc_q.size(), 206);

    // Randomized bursts, half of them near a 64 KiB boundary.
    for (int k = 0; k < 6; k++) begin
      a = $urandom;
      if (k % 2 == 1) a[15:0] = 16'hFFF0 | 16'($urandom_range(0, 15));
      l = 8'($urandom_range(0, 24));
      run("rand", a, l, 2);
    end

    // Maximum length burst crossing a 64 KiB boundary.
    run("maxlen", 32'h1000_FF00, 8'd255, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/n64_pi_master.md
N64_PI_MASTER -- requirements
Module: n64_pi_master

Interface
REQ-001 SHALL have parameter ALE_CYC, default 4: clock cycles per address phase and per turnaround gap (range 1..255).
REQ-002 SHALL have parameter RD_LOW_CYC, default 8: clock cycles READ_N is held low per halfword (range 2..255).
REQ-003 SHALL have parameter RD_HIGH_CYC, default 4: clock cycles READ_N is held high between halfwords (range 1..255).
REQ-004 Port: clock, input, 1, single clock; all logic on its rising edge.
REQ-005 Port: reset, input, 1, asynchronous, active-high.
REQ-006 Port: req_valid, input, 1, burst request.
REQ-007 Port: req_ready, output, 1, high only in IDLE.
REQ-008 Port: req_addr, input, 32, byte address; bit 0 ignored (treated as 0).
REQ-009 Port: req_len, input, 8, halfword count minus one (1..256 halfwords).
REQ-010 Port: resp_valid, output, 1, one-cycle pulse per halfword; no backpressure.
REQ-011 Port: resp_data, output, 16, halfword read.
REQ-012 Port: resp_last, output, 1, qualifies the final halfword of a burst.
REQ-013 Port: busy, output, 1, high in every state except IDLE.
REQ-014 Ports: pi_ad_o (output, 16), pi_ad_oe (output, 1), pi_ad_i (input, 16): split AD bus; top level drives pads from pi_ad_o when pi_ad_oe is high.
REQ-015 Ports: pi_ale_h, pi_ale_l, pi_read_n, outputs, 1 each, cartridge bus strobes.

Function
REQ-016 SHALL implement states IDLE, AHI, ALO, GAP, RDL, RDH; each timed state lasts exactly its parameter count.
REQ-017 IDLE: ale_h=0, ale_l=0, read_n=1, oe=0; req_valid&&req_ready latches addr/len and enters AHI on the next cycle.
REQ-018 AHI (ALE_CYC): ale_h=1, ale_l=1, oe=1, pi_ad_o=addr[31:16].
REQ-019 ALO (ALE_CYC): ale_h=0, ale_l=1, oe=1, pi_ad_o=addr[15:0].
REQ-020 GAP (ALE_CYC): ale_l=0, oe=0 (bus turnaround).
REQ-021 RDL (RD_LOW_CYC): read_n=0, oe=0; pi_ad_i SHALL be sampled on the last RDL cycle.
REQ-022 resp_valid SHALL pulse on the cycle after sampling, with resp_data=sample and resp_last=1 iff remaining count was zero.
REQ-023 RDH (RD_HIGH_CYC): read_n=1; the internal address increments by 2; the remaining count decrements.
REQ-024 After RDH: remaining==0 -> IDLE; else if the incremented addr[15:0]==0x0000 (16-bit wrap) -> AHI with the new upper half; else -> RDL.
REQ-025 Address SHALL wrap 0xFFFF_FFFE -> 0x0000_0000 without error.
REQ-026 req_valid during busy SHALL be ignored (req_ready=0); no queueing.
REQ-027 oe and read_n low SHALL never be asserted in the same cycle.

Reset
REQ-028 Reset SHALL asynchronously force IDLE and the REQ-017 output values, with resp_valid=0, resp_last=0, resp_data=0, req_ready=0 while asserted, and timer/count/addr=0.
REQ-029 Reset mid-burst SHALL abort with no further resp_valid; req_ready SHALL rise on the first clock after deassertion.

Configuration
REQ-030 Macro N64_PI_MASTER_INPUT_REG_EN: when defined, pi_ad_i SHALL pass through one input register, sampling SHALL use the register on the first RDH cycle, and resp_valid SHALL be delayed by one cycle; RDH length is unchanged.
REQ-031 When the macro is undefined, the behaviour of REQ-021/022 applies.

Structure
REQ-032 Package n64_pi_pkg SHALL hold the state enum, default timing constants, and the AD width constant.
REQ-033 Sub-module n64_pi_timer (loadable down-counter with done flag) SHALL time all phases.

Verification
REQ-034 Single read addr=0x1000_0000, len=0, cart model returns 0x8037 -> one resp_valid, data 0x8037, resp_last=1; ale_h high 4 cycles with AD=0x1000; ale_l high 8 cycles; AD=0x0000 during ALO.
REQ-035 Burst addr=0x1000_0040, len=3, model returns addr[15:0] -> data 0x0040,0x0042,0x0044,0x0046; exactly one address phase; last pulse has resp_last=1.
REQ-036 Wrap: addr=0x1000_FFFC, len=3 -> second address phase after 2 halfwords with AD=0x1001 then 0x0000; data continues correctly.
REQ-037 Reset asserted during the 2nd RDL of a len=7 burst -> outputs idle immediately, no more resp_valid, req_ready=1 one clock after release.
REQ-038 req_valid held high through a burst -> only one burst executes; the second is accepted only once IDLE is reached; oe/read_n overlap check never fires.
REQ-039 With N64_PI_MASTER_INPUT_REG_EN defined, repeat REQ-034 -> identical data, resp_valid one cycle later.
